jump_redirect_ctrl: RTL and testbench

- Consumer end of the EX-stage jump flags (`jal`/`jalr` registered out of the IF/ID→EX jump-flag pipeline register).
- Computes the jump target and link address, and drives a PC redirect to the fetch stage.
- Generates the flush pulse that clears the wrong-path jump-flag and instruction registers (their `rst_ir` input).
- Small FSM that sequences redirect and multi-cycle flush, honouring pipeline stalls.

---
 rtl/jump_redirect_ctrl.sv | 115 +++++++++++
 tb/tb_jump_redirect_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/jump_redirect_ctrl.sv
// EX-stage jump resolution: computes JAL/JALR target and link address, then
// sequences a one-cycle PC redirect followed by a stall-aware multi-cycle flush.
module jump_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            valid_ex,
    input  logic            jal_ex,
    input  logic            jalr_ex,
    input  logic [XLEN-1:0] pc_ex,
    input  logic [XLEN-1:0] imm_ex,
    input  logic [XLEN-1:0] rs1_val,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_target,
    output logic            flush_ir,
    output logic [XLEN-1:0] link_addr,
    output logic            misalign_exc,
    output logic            busy,
    output logic [31:0]     jump_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t          state_reg;
    logic [3:0]      cnt_reg;

    logic [XLEN-1:0] jal_target;
    logic [XLEN-1:0] jalr_target;
    logic [XLEN-1:0] target_next;
    logic [XLEN-1:0] link_next;
    logic            candidate;
    logic            misaligned;

    always_comb begin
        jal_target  = pc_ex + imm_ex;
        jalr_target = (rs1_val + imm_ex) & ~XLEN'(1);
        // JAL wins if both flags are set
        target_next = jal_ex ? jal_target : jalr_target;
        link_next   = pc_ex + XLEN'(4);
        candidate   = (state_reg == IDLE) && valid_ex && !stall && (jal_ex || jalr_ex);
        misaligned  = target_next[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            redirect_valid  <= 1'b0;
            flush_ir        <= 1'b0;
            busy            <= 1'b0;
            misalign_exc    <= 1'b0;
            redirect_target <= '0;
            link_addr       <= '0;
            jump_cnt        <= '0;
        end else begin
            misalign_exc <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (candidate) begin
                        if (misaligned) begin
                            misalign_exc <= 1'b1;
                        end else begin
                            redirect_target <= target_next;
                            link_addr       <= link_next;
                            jump_cnt        <= jump_cnt + 32'd1;
                            state_reg       <= REDIRECT;
                            redirect_valid  <= 1'b1;
                            flush_ir        <= 1'b1;
                            busy            <= 1'b1;
                        end
                    end
                end
                REDIRECT: begin
                    // Fetch only consumes the redirect on an unstalled cycle
                    if (!stall) begin
                        redirect_valid <= 1'b0;
                        if (FLUSH_CYCLES == 1) begin
                            state_reg <= IDLE;
                            flush_ir  <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            state_reg <= FLUSH;
                            cnt_reg   <= 4'(FLUSH_CYCLES - 2);
                        end
                    end
                end
                FLUSH: begin
                    if (!stall) begin
                        if (cnt_reg == 4'd0) begin
                            state_reg <= IDLE;
                            flush_ir  <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg - 4'd1;
                        end
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    redirect_valid <= 1'b0;
                    flush_ir       <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Directed bench for jump_redirect_ctrl (XLEN=32, FLUSH_CYCLES=2).
module tb_jump_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        valid_ex;
    logic        jal_ex;
    logic        jalr_ex;
    logic [31:0] pc_ex;
    logic [31:0] imm_ex;
    logic [31:0] rs1_val;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        flush_ir;
    logic [31:0] link_addr;
    logic        misalign_exc;
    logic        busy;
    logic [31:0] jump_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jump_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .valid_ex        (valid_ex),
        .jal_ex          (jal_ex),
        .jalr_ex         (jalr_ex),
        .pc_ex           (pc_ex),
        .imm_ex          (imm_ex),
        .rs1_val         (rs1_val),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .flush_ir        (flush_ir),
        .link_addr       (link_addr),
        .misalign_exc    (misalign_exc),
        .busy            (busy),
        .jump_cnt        (jump_cnt)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end else begin
            $display("ok   %s: 0x%08h", tag, actual);
        end
    endtask

    // Advance one clock; inputs and checks happen 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_ex = 1'b0;
        jal_ex   = 1'b0;
        jalr_ex  = 1'b0;
    endtask

    task automatic present(input logic jal, input logic jalr, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [31:0] rs1);
        valid_ex = 1'b1;
        jal_ex   = jal;
        jalr_ex  = jalr;
        pc_ex    = pc;
        imm_ex   = imm;
        rs1_val  = rs1;
    endtask

    task automatic check_ctl(input string tag, input logic rv, input logic fl, input logic bz, input logic me);
        check({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(rv));
        check({tag, ".flush_ir"},       32'(flush_ir),       32'(fl));
        check({tag, ".busy"},           32'(busy),           32'(bz));
        check({tag, ".misalign_exc"},   32'(misalign_exc),   32'(me));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0;
        pc_ex = '0; imm_ex = '0; rs1_val = '0;
        idle_inputs();
        step(); step();
        check_ctl("reset", 0, 0, 0, 0);
        check("reset.target",   redirect_target, 32'h0);
        check("reset.link",     link_addr,       32'h0);
        check("reset.jump_cnt", jump_cnt,        32'h0);
        rst = 1'b0;

        // Plain JAL, FLUSH_CYCLES=2
        present(1, 0, 32'h100, 32'h20, 32'h0);
        step(); idle_inputs();
        check_ctl("jal.c1", 1, 1, 1, 0);
        check("jal.target",   redirect_target, 32'h120);
        check("jal.link",     link_addr,       32'h104);
        check("jal.jump_cnt", jump_cnt,        32'd1);
        step();
        check_ctl("jal.c2", 0, 1, 1, 0);
        step();
        check_ctl("jal.c3", 0, 0, 0, 0);

        // JALR clears bit0
        present(0, 1, 32'h200, 32'h4, 32'h2001);
        step(); idle_inputs();
        check_ctl("jalr.c1", 1, 1, 1, 0);
        check("jalr.target",   redirect_target, 32'h2004);
        check("jalr.link",     link_addr,       32'h204);
        check("jalr.jump_cnt", jump_cnt,        32'd2);
        step(); step();
        check_ctl("jalr.done", 0, 0, 0, 0);

        // Misaligned target
        present(1, 0, 32'h100, 32'h2, 32'h0);
        step(); idle_inputs();
        check_ctl("mis.c1", 0, 0, 0, 1);
        check("mis.jump_cnt", jump_cnt,        32'd2);
        check("mis.target",   redirect_target, 32'h2004);
        step();
        check_ctl("mis.c2", 0, 0, 0, 0);

        // Stalled redirect, then wrong-path JAL during FLUSH
        present(1, 0, 32'h300, 32'h10, 32'h0);
        step(); idle_inputs(); stall = 1'b1;
        check_ctl("stall.c1", 1, 1, 1, 0);
        step();
        check_ctl("stall.c2", 1, 1, 1, 0);
        step();
        check_ctl("stall.c3", 1, 1, 1, 0);
        step(); stall = 1'b0;
        check_ctl("stall.c4", 1, 1, 1, 0);
        step();
        check_ctl("stall.flush", 0, 1, 1, 0);
        present(1, 0, 32'h400, 32'h0, 32'h0);
        step(); idle_inputs();
        check_ctl("stall.idle", 0, 0, 0, 0);
        check("wrongpath.jump_cnt", jump_cnt,        32'd3);
        check("wrongpath.target",   redirect_target, 32'h310);
        step();
        check_ctl("wrongpath.after", 0, 0, 0, 0);

        // Address wrap
        present(1, 0, 32'hFFFF_FFFC, 32'h8, 32'h0);
        step(); idle_inputs();
        check("wrap.target", redirect_target, 32'h4);
        check("wrap.link",   link_addr,       32'h0);
        check("wrap.jump_cnt", jump_cnt,      32'd4);

        // Reset in first FLUSH cycle, then immediate JAL
        step();
        check_ctl("rst.flush", 0, 1, 1, 0);
        rst = 1'b1;
        step(); rst = 1'b0;
        check_ctl("rst.after", 0, 0, 0, 0);
        check("rst.jump_cnt", jump_cnt,        32'h0);
        check("rst.target",   redirect_target, 32'h0);
        check("rst.link",     link_addr,       32'h0);
        present(1, 0, 32'h500, 32'h40, 32'h0);
        step(); idle_inputs();
        check_ctl("postrst.c1", 1, 1, 1, 0);
        check("postrst.target",   redirect_target, 32'h540);
        check("postrst.link",     link_addr,       32'h504);
        check("postrst.jump_cnt", jump_cnt,        32'd1);
        step(); step();

        // Both flags set: JAL target wins; presented the cycle FSM returns to IDLE
        present(1, 1, 32'h600, 32'h8, 32'h1000);
        step(); idle_inputs();
        check_ctl("prio.c1", 1, 1, 1, 0);
        check("prio.target",   redirect_target, 32'h608);
        check("prio.jump_cnt", jump_cnt,        32'd2);
        step(); step();
        check_ctl("prio.done", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
